// File: rtl/expr_char_tx.sv
// expr_char_tx: serialises a packed expression request into an ASCII stream of
// the form D(OP D)* over a valid/ready byte interface.
`timescale 1ns/1ps
module expr_char_tx #(
  parameter int MAX_OPS = 4,
  parameter int CW      = 3
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 start,
  input  logic [CW-1:0]        num_ops,
  input  logic [4*MAX_OPS-1:0] operands,
  input  logic [MAX_OPS-2:0]   ops,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_char,
  output logic                 out_last,
  output logic                 done,
  output logic                 err
);

  localparam int IW = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIGIT = 2'd1,
    S_OP    = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_digits [MAX_OPS];
  logic [MAX_OPS-2:0] r_ops;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      r_last_idx;
  logic               r_err;

  logic               w_illegal;
  logic               w_load;
  logic               w_inc;
  logic               w_is_last;

  // Only digits actually used by the expression are range-checked.
  always_comb begin
    w_illegal = (num_ops == '0) || (num_ops > CW'(MAX_OPS));
    for (int i = 0; i < MAX_OPS; i++) begin
      if ((CW'(i) < num_ops) && (operands[4*i +: 4] > 4'd9)) begin
        w_illegal = 1'b1;
      end
    end
  end

  assign w_is_last = (r_idx == r_last_idx);

  // NOTE: every output and control signal gets a default before the case so
  // no path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_inc        = 1'b0;
    busy         = 1'b0;
    out_valid    = 1'b0;
    out_char     = 8'h00;
    out_last     = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !w_illegal) begin
          w_next_state = S_DIGIT;
          w_load       = 1'b1;
        end
      end
      S_DIGIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_char  = 8'h30 + {4'h0, r_digits[r_idx]};
        out_last  = w_is_last;
        if (out_ready) begin
          w_next_state = w_is_last ? S_FIN : S_OP;
        end
      end
      S_OP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_char  = r_ops[r_idx] ? 8'h2A : 8'h2B;
        if (out_ready) begin
          w_next_state = S_DIGIT;
          w_inc        = 1'b1;
        end
      end
      S_FIN: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_err   <= (r_state == S_IDLE) && start && w_illegal;
    end
  end

  // NOTE: the request latches are cleared on reset as well, so nothing from an
  // aborted stream survives into the next one.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < MAX_OPS; i++) r_digits[i] <= 4'h0;
      r_ops      <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
    end else if (w_load) begin
      for (int i = 0; i < MAX_OPS; i++) r_digits[i] <= operands[4*i +: 4];
      r_ops      <= ops;
      r_idx      <= '0;
      r_last_idx <= IW'(num_ops - CW'(1));
    end else if (w_inc) begin
      r_idx <= r_idx + IW'(1);
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_expr_char_tx.sv
// Self-checking bench for expr_char_tx: directed scenarios plus randomized
// requests compared against a string-building reference model.
`timescale 1ns/1ps
module tb_expr_char_tx;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [2:0]  num_ops;
  logic [15:0] operands;
  logic [2:0]  ops;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_char;
  logic        out_last;
  logic        done;
  logic        err;

  int checks;
  int errors;

  expr_char_tx #(.MAX_OPS(4), .CW(3)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .num_ops  (num_ops),
    .operands (operands),
    .ops      (ops),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_char (out_char),
    .out_last (out_last),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the expression text the request describes.
  function automatic void build_expr(input int n, input logic [15:0] opr,
                                     input logic [2:0] opv, output byte q[$]);
    q = {};
    for (int i = 0; i < n; i++) begin
      logic [3:0] d;
      d = opr[4*i +: 4];
      q.push_back(byte'("0") + byte'(d));
      if (i < n - 1) q.push_back(opv[i] ? byte'("*") : byte'("+"));
    end
  endfunction

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({busy, out_valid, out_char, out_last, done} !== 12'h000) begin
      errors++;
      $display("FAIL %s: busy=%b valid=%b char=%h last=%b done=%b, want all zero",
               name, busy, out_valid, out_char, out_last, done);
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: 3-cycle stall on char 2.
  task automatic run_req(input int n, input logic [15:0] opr, input logic [2:0] opv,
                         input int mode, input bit restart, input string name);
    byte  exp[$];
    int   pos, cyc, stall;
    bit   held, rdy, aborted;
    logic [7:0] prev_char;
    logic       prev_last;
    build_expr(n, opr, opv, exp);
    start = 1'b1; num_ops = 3'(n); operands = opr; ops = opv; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    operands = 16'($urandom); ops = 3'($urandom); num_ops = 3'($urandom);
    pos = 0; cyc = 0; stall = 0; held = 1'b0; aborted = 1'b0;
    prev_char = 8'h00; prev_last = 1'b0;
    while (pos < exp.size() && cyc < 200 && !aborted) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
        errors++; aborted = 1'b1;
        $display("FAIL %s valid/busy pos %0d: valid=%b busy=%b err=%b done=%b, want 1 1 0 0",
                 name, pos, out_valid, busy, err, done);
      end else begin
        if (held) begin
          checks++;
          if (out_char !== prev_char || out_last !== prev_last) begin
            errors++;
            $display("FAIL %s hold pos %0d: char=%h last=%b, want %h %b",
                     name, pos, out_char, out_last, prev_char, prev_last);
          end
        end
        checks++;
        if (out_char !== 8'(exp[pos]) || out_last !== (pos == exp.size() - 1)) begin
          errors++;
          $display("FAIL %s char pos %0d: char=%h last=%b, want %h %b", name, pos,
                   out_char, out_last, 8'(exp[pos]), (pos == exp.size() - 1));
        end
        case (mode)
          0: rdy = 1'b1;
          1: rdy = ($urandom_range(0, 2) != 0);
          default: begin
            if (pos == 2 && stall < 3) begin rdy = 1'b0; stall++; end
            else rdy = 1'b1;
          end
        endcase
        if (restart && cyc == 1) begin
          start = 1'b1; num_ops = 3'd4; operands = 16'h8888; ops = 3'b111;
        end else begin
          start = 1'b0;
        end
        out_ready = rdy;
        held = !rdy; prev_char = out_char; prev_last = out_last;
        if (rdy) pos++;
        cyc++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    checks++;
    if (pos != exp.size()) begin
      errors++;
      $display("FAIL %s stream incomplete: sent %0d, want %0d", name, pos, exp.size());
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_char !== 8'h00) begin
      errors++;
      $display("FAIL %s done cycle: done=%b busy=%b valid=%b char=%h, want 1 0 0 00",
               name, done, busy, out_valid, out_char);
    end
    // A start presented during FIN must be ignored.
    start = 1'b1; num_ops = 3'd1; operands = 16'h0005; ops = 3'b000;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: valid=%b busy=%b done=%b err=%b, want 0 0 0 0",
               name, out_valid, busy, done, err);
    end
    @(negedge clk);
    check_idle_outputs({name, " idle"});
  endtask

  task automatic err_req(input int n, input logic [15:0] opr, input string name);
    start = 1'b1; num_ops = 3'(n); operands = opr; ops = 3'($urandom); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s err pulse: err=%b valid=%b busy=%b, want 1 0 0",
               name, err, out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_char !== 8'h00) begin
      errors++;
      $display("FAIL %s after err: err=%b valid=%b busy=%b char=%h, want 0 0 0 00",
               name, err, out_valid, busy, out_char);
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b0; num_ops = '0; operands = '0; ops = '0; out_ready = 1'b0;
    #1;
    check_idle_outputs("reset during");
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset err: err=%b, want 0", err);
    end
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset released");
  endtask

  task automatic test_single();
    run_req(1, 16'h0007, 3'b000, 0, 1'b0, "n1_digit7");
  endtask

  task automatic test_three();
    run_req(3, 16'h0321, 3'b010, 0, 1'b0, "n3_1p2t3");
  endtask

  task automatic test_backpressure();
    run_req(3, 16'h0321, 3'b010, 2, 1'b0, "stall_on_2");
  endtask

  task automatic test_illegal();
    err_req(0, 16'h0000, "n0");
    err_req(5, 16'h1234, "n5");
    err_req(2, 16'h00A3, "digit1_A");
    run_req(2, 16'hF054, 3'b000, 0, 1'b0, "digit3_F_unused");
  endtask

  task automatic test_midstream_start();
    run_req(3, 16'h0456, 3'b001, 0, 1'b1, "restart_ignored");
  endtask

  task automatic test_async_reset();
    start = 1'b1; num_ops = 3'd3; operands = 16'h0321; ops = 3'b010; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (out_char !== 8'h2B || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL async pre: char=%h valid=%b, want 2b 1", out_char, out_valid);
    end
    out_ready = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
    @(negedge clk);
    check_idle_outputs("async reset held");
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL async reset err: err=%b, want 0", err);
    end
    clr_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after release");
    run_req(2, 16'h0009, 3'b001, 0, 1'b0, "fresh_9t0");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 20; k++) begin
      int          n;
      logic [15:0] opr;
      n = $urandom_range(1, 4);
      opr = 16'($urandom);
      for (int i = 0; i < n; i++) opr[4*i +: 4] = 4'($urandom_range(0, 9));
      run_req(n, opr, 3'($urandom), (k % 3 == 0) ? 0 : 1, 1'b0, $sformatf("rand%0d", k));
    end
    for (int k = 0; k < 6; k++) begin
      int          n, bad;
      logic [15:0] opr;
      n = $urandom_range(1, 4);
      bad = $urandom_range(0, n - 1);
      opr = 16'($urandom);
      for (int i = 0; i < n; i++) opr[4*i +: 4] = 4'($urandom_range(0, 9));
      opr[4*bad +: 4] = 4'($urandom_range(10, 15));
      err_req(n, opr, $sformatf("rand_bad%0d", k));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_three();
    test_backpressure();
    test_illegal();
    test_midstream_start();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
